// File: rtl/dec_nbload_scoreboard.sv
// dec_nbload_scoreboard: tracks outstanding non-blocking loads, flags RAW hazards and
// gates the late register-file write on load return (cancelled by younger WAW writers).
module dec_nbload_scoreboard #(
    parameter int DEPTH = 4,
    parameter int TAGW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int NQ    = 4
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            flush_all_i,
    input  logic            alloc_valid_i,
    input  logic [TAGW-1:0] alloc_tag_i,
    input  logic [4:0]      alloc_rd_i,
    input  logic            alloc_fp_i,
    input  logic            cancel_valid_i,
    input  logic [TAGW-1:0] cancel_tag_i,
    input  logic            ret_valid_i,
    input  logic [TAGW-1:0] ret_tag_i,
    input  logic            ret_error_i,
    input  logic            wr_valid_i,
    input  logic [4:0]      wr_rd_i,
    input  logic            wr_fp_i,
    input  logic [NQ-1:0]   q_valid_i,
    input  logic [5*NQ-1:0] q_addr_i,
    input  logic [NQ-1:0]   q_fp_i,
    output logic [NQ-1:0]   hazard_o,
    output logic            ret_wen_o,
    output logic [4:0]      ret_rd_o,
    output logic            ret_fp_o,
    output logic [TAGW:0]   count_o,
    output logic            full_o,
    output logic            alloc_coll_o
);
    logic [DEPTH-1:0] valid, wb, fp;
    logic [4:0]       rd [DEPTH];
    logic [DEPTH-1:0] valid_n, wb_n, fp_n;
    logic [4:0]       rd_n [DEPTH];
    logic [DEPTH-1:0] freed, waw, ahit;
    logic [TAGW:0]    count_n;
    logic             alloc_wb, wr_int0;

    assign alloc_wb = !(alloc_rd_i == 5'd0 && !alloc_fp_i);
    assign wr_int0  = wr_rd_i == 5'd0 && !wr_fp_i;

    // Allocation is applied last, so it overrides any same-cycle free or WAW clear.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ahit[i]    = alloc_valid_i && alloc_tag_i == TAGW'(i);
        assign freed[i]   = (ret_valid_i && ret_tag_i == TAGW'(i)) ||
                            (cancel_valid_i && cancel_tag_i == TAGW'(i));
        assign waw[i]     = wr_valid_i && !wr_int0 && rd[i] == wr_rd_i && fp[i] == wr_fp_i;
        assign valid_n[i] = ahit[i] | (valid[i] & !freed[i]);
        assign wb_n[i]    = ahit[i] ? alloc_wb : wb[i] & !freed[i] & !waw[i];
        assign rd_n[i]    = ahit[i] ? alloc_rd_i : rd[i];
        assign fp_n[i]    = ahit[i] ? alloc_fp_i : fp[i];
    end

    always_comb begin
        count_n = '0;
        for (int i = 0; i < DEPTH; i++)
            count_n = count_n + (TAGW+1)'(valid_n[i]);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l || flush_all_i) begin
            valid   <= '0;
            wb      <= '0;
            fp      <= '0;
            count_o <= '0;
            for (int i = 0; i < DEPTH; i++)
                rd[i] <= 5'd0;
        end else begin
            valid   <= valid_n;
            wb      <= wb_n;
            fp      <= fp_n;
            count_o <= count_n;
            for (int i = 0; i < DEPTH; i++)
                rd[i] <= rd_n[i];
        end
    end

    always_comb begin
        hazard_o = '0;
        for (int k = 0; k < NQ; k++)
            for (int i = 0; i < DEPTH; i++)
                if (q_valid_i[k] && valid[i] && wb[i] && rd[i] == q_addr_i[5*k +: 5] && fp[i] == q_fp_i[k])
                    hazard_o[k] = 1'b1;
    end

    assign ret_wen_o    = ret_valid_i && valid[ret_tag_i] && wb[ret_tag_i] && !ret_error_i;
    assign ret_rd_o     = valid[ret_tag_i] ? rd[ret_tag_i] : 5'd0;
    assign ret_fp_o     = valid[ret_tag_i] && fp[ret_tag_i];
    assign full_o       = count_o == (TAGW+1)'(DEPTH);
    assign alloc_coll_o = alloc_valid_i && valid[alloc_tag_i] &&
                          !(ret_valid_i && ret_tag_i == alloc_tag_i) &&
                          !(cancel_valid_i && cancel_tag_i == alloc_tag_i);
endmodule

// File: tb/tb_dec_nbload_scoreboard.sv
// tb_dec_nbload_scoreboard: directed scenarios plus random traffic checked against a
// sequential-semantics reference model of the load table.
module tb_dec_nbload_scoreboard;
    logic       clk = 0;
    logic       rst_l;
    logic       flush, av, afp, cv, rv, rerr, wv, wfp;
    logic [1:0] at, ct, rt;
    logic [4:0] ard, wrd;
    logic [3:0] qv, qf;
    logic [19:0] qa;
    logic [3:0] hazard;
    logic       wen, rfp, full, coll;
    logic [4:0] rrd;
    logic [2:0] count;

    int checks = 0, errors = 0;
    bit   mv [4], mwb [4], mfp [4];
    logic [4:0] mrd [4];
    logic [3:0] obs_hz;
    logic obs_wen, obs_coll;
    logic [4:0] obs_rd;

    dec_nbload_scoreboard dut (
        .clk(clk), .rst_l(rst_l), .flush_all_i(flush),
        .alloc_valid_i(av), .alloc_tag_i(at), .alloc_rd_i(ard), .alloc_fp_i(afp),
        .cancel_valid_i(cv), .cancel_tag_i(ct),
        .ret_valid_i(rv), .ret_tag_i(rt), .ret_error_i(rerr),
        .wr_valid_i(wv), .wr_rd_i(wrd), .wr_fp_i(wfp),
        .q_valid_i(qv), .q_addr_i(qa), .q_fp_i(qf),
        .hazard_o(hazard), .ret_wen_o(wen), .ret_rd_o(rrd), .ret_fp_o(rfp),
        .count_o(count), .full_o(full), .alloc_coll_o(coll)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        {flush, av, afp, cv, rv, rerr, wv, wfp} = '0;
        {at, ct, rt} = '0;
        ard = 0; wrd = 0; qv = 0; qf = 0; qa = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mv[i] = 0; mwb[i] = 0; mfp[i] = 0; mrd[i] = 0;
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 4; i++) n += mv[i];
        return n;
    endfunction

    // Events applied in program order: WAW, frees, then alloc overrides.
    task automatic model_edge();
        if (flush) begin
            model_clear();
            return;
        end
        if (wv && !(wrd == 0 && !wfp))
            for (int i = 0; i < 4; i++)
                if (mv[i] && mrd[i] == wrd && mfp[i] == wfp) mwb[i] = 0;
        if (rv && mv[rt]) begin mv[rt] = 0; mwb[rt] = 0; end
        if (cv && mv[ct]) begin mv[ct] = 0; mwb[ct] = 0; end
        if (av) begin
            mv[at] = 1; mrd[at] = ard; mfp[at] = afp;
            mwb[at] = !(ard == 0 && !afp);
        end
    endtask

    task automatic tick();
        logic [3:0] ehz;
        #1;
        ehz = 0;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++)
                if (qv[k] && mv[i] && mwb[i] && mrd[i] == qa[5*k +: 5] && mfp[i] == qf[k]) ehz[k] = 1;
        obs_hz = hazard; obs_wen = wen; obs_rd = rrd; obs_coll = coll;
        chk("hazard", hazard, ehz);
        chk("ret_wen", wen, rv && mv[rt] && mwb[rt] && !rerr);
        chk("ret_rd", rrd, mv[rt] ? mrd[rt] : 5'd0);
        chk("ret_fp", rfp, mv[rt] && mfp[rt]);
        chk("coll", coll, av && mv[at] && !(rv && rt == at) && !(cv && ct == at));
        @(posedge clk);
        model_edge();
        #1;
        chk("count", count, model_count());
        chk("full", full, model_count() == 4);
        @(negedge clk);
    endtask

    task automatic alloc(input logic [1:0] t, input logic [4:0] r, input logic f);
        idle(); av = 1; at = t; ard = r; afp = f; tick();
    endtask

    initial begin
        idle();
        model_clear();
        rst_l = 0;
        repeat (2) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_hazard", hazard, 0);
        chk("rst_wen", wen, 0);
        rst_l = 1;
        @(negedge clk);

        alloc(1, 5, 0);
        chk("cnt_after_alloc", count, 1);
        idle(); qv = 4'b0011; qa[4:0] = 5; qa[9:5] = 5; qf = 4'b0010; tick();
        chk("hz_x5_int", obs_hz[0], 1);
        chk("hz_x5_fp", obs_hz[1], 0);

        alloc(2, 7, 0);
        chk("cnt2", count, 2);
        idle(); wv = 1; wrd = 7; tick();
        idle(); rv = 1; rt = 2; tick();
        chk("waw_wen", obs_wen, 0);
        chk("waw_rd", obs_rd, 7);
        chk("cnt_drop", count, 1);

        alloc(0, 1, 0); alloc(2, 2, 0); alloc(3, 3, 0);
        chk("full_set", full, 1);
        idle(); rv = 1; rt = 0; av = 1; at = 0; ard = 4; afp = 1; tick();
        chk("swap_coll", obs_coll, 0);
        chk("swap_full", full, 1);

        idle(); cv = 1; ct = 3; tick();
        alloc(3, 0, 0);
        idle(); qv = 4'b0001; tick();
        chk("hz_x0", obs_hz[0], 0);
        idle(); rv = 1; rt = 3; tick();
        chk("x0_wen", obs_wen, 0);
        chk("x0_cnt", count, 3);

        idle(); rv = 1; rt = 1; rerr = 1; tick();
        chk("err_wen", obs_wen, 0);
        chk("err_cnt", count, 2);
        alloc(2, 9, 0);
        chk("coll_pulse", obs_coll, 1);
        chk("coll_cnt", count, 2);

        idle(); flush = 1; av = 1; at = 1; ard = 6; tick();
        chk("flush_cnt", count, 0);

        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                alloc(0, 3, 0); alloc(1, 4, 1);
                rst_l = 0;
                #1;
                model_clear();
                chk("arst_count", count, 0);
                chk("arst_full", full, 0);
                @(negedge clk);
                rst_l = 1;
            end
            idle();
            flush = $urandom_range(0, 39) == 0;
            av = $urandom_range(0, 1); at = 2'($urandom); ard = 5'($urandom_range(0, 7)); afp = $urandom_range(0, 3) == 0;
            cv = $urandom_range(0, 6) == 0; ct = 2'($urandom);
            rv = $urandom_range(0, 2) == 0; rt = 2'($urandom); rerr = $urandom_range(0, 4) == 0;
            wv = $urandom_range(0, 2) == 0; wrd = 5'($urandom_range(0, 7)); wfp = $urandom_range(0, 3) == 0;
            qv = 4'($urandom); qf = 4'($urandom & $urandom);
            for (int k = 0; k < 4; k++) qa[5*k +: 5] = 5'($urandom_range(0, 7));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
